bcd_scan_display: RTL and testbench

- Downstream consumer of the 3-digit BCD word from the binary-to-BCD converter.
- Time-multiplexes three 7-segment digits over a shared active-low segment bus and active-low digit enables.
- Latches new values through a shadow register and commits them only at a frame boundary, so a scan frame never shows mixed old/new digits.
- Blanks all digits for one clock at every digit switch to suppress ghosting.

---
 rtl/bcd_scan_display.sv | 167 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed 7-segment driver for a BCD word, with frame-aligned commit and a one-clock blank at every digit switch.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_display #(
    parameter int REFRESH_DIV = 27000,
    parameter int CNT_W       = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        pending
);

    typedef enum logic [1:0] {
        S_U = 2'd0,
        S_T = 2'd1,
        S_H = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             tick;
    logic             blank_reg;
    logic [11:0]      shadow_reg, shadow_next;
    logic [11:0]      disp_reg, disp_next;
    logic             pending_reg, pending_next;
    logic [6:0]       seg_reg, seg_next;
    logic [2:0]       an_reg, an_next;
    logic             commit;
    logic [3:0]       nib [3];
    logic [3:0]       digit;
    logic [2:0]       digit_en;
    logic             digit_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_nib
            assign nib[gi] = disp_reg[4*gi +: 4];
        end
    endgenerate

    assign tick = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_U;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                S_U:     state_next = S_T;
                S_T:     state_next = S_H;
                default: state_next = S_U;
            endcase
        end
    end

    always_comb begin
        cnt_next = tick ? '0 : cnt_reg + 1'b1;
    end

    // Commit reads the shadow before this cycle's load can overwrite it.
    always_comb begin
        commit       = tick && (state_reg == S_H) && pending_reg;
        disp_next    = commit ? shadow_reg : disp_reg;
        shadow_next  = load ? bcd : shadow_reg;
        pending_next = pending_reg;
        if (commit) begin
            pending_next = 1'b0;
        end
        if (load) begin
            pending_next = 1'b1;
        end
    end

    always_comb begin
        case (state_reg)
            S_U: begin
                digit_en = 3'b110;
                digit    = nib[0];
            end
            S_T: begin
                digit_en = 3'b101;
                digit    = nib[1];
            end
            default: begin
                digit_en = 3'b011;
                digit    = nib[2];
            end
        endcase
    end

`ifdef BCD_SCAN_LZB_EN
    always_comb begin
        digit_blank = ((state_reg == S_H) && (disp_reg[11:8] == 4'd0)) ||
                      ((state_reg == S_T) && (disp_reg[11:4] == 8'd0));
    end
`else
    always_comb begin
        digit_blank = 1'b0;
    end
`endif

    // blank_reg marks the blank cycle; the new digit is driven on the edge that ends it.
    always_comb begin
        an_next  = an_reg;
        seg_next = seg_reg;
        if (tick) begin
            an_next = 3'b111;
        end else if (blank_reg) begin
            an_next  = digit_en;
            seg_next = digit_blank ? SEG_OFF : seg_decode(digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            blank_reg   <= 1'b0;
            shadow_reg  <= '0;
            disp_reg    <= '0;
            pending_reg <= 1'b0;
            an_reg      <= 3'b111;
            seg_reg     <= SEG_OFF;
        end else begin
            cnt_reg     <= cnt_next;
            blank_reg   <= tick;
            shadow_reg  <= shadow_next;
            disp_reg    <= disp_next;
            pending_reg <= pending_next;
            an_reg      <= an_next;
            seg_reg     <= seg_next;
        end
    end

    assign seg     = seg_reg;
    assign an      = an_reg;
    assign pending = pending_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus random loads against a cycle-level behavioural model.
module tb_bcd_scan_display;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic [11:0] bcd;
    logic        load;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        pending;

    bcd_scan_display #(.REFRESH_DIV(N), .CNT_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bcd     (bcd),
        .load    (load),
        .seg     (seg),
        .an      (an),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] pat_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    int n_assert = 0;
    int n_fail   = 0;

    // Model: edges since reset, ticks seen, registers, expected outputs.
    int         m_cyc;
    int         m_nt;
    logic       m_prev_tick;
    logic [11:0] m_shadow, m_disp;
    logic       m_pend;
    logic [2:0] m_an;
    logic [6:0] m_seg;

    logic watch_bad;
    logic seen_bad;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc       = 0;
        m_nt        = 0;
        m_prev_tick = 1'b0;
        m_shadow    = 12'h000;
        m_disp      = 12'h000;
        m_pend      = 1'b0;
        m_an        = 3'b111;
        m_seg       = 7'b1111111;
    endtask

    // Pattern the display slot idx (0=units,1=tens,2=hundreds) should show now.
    function automatic logic [6:0] exp_pat(input int idx);
        logic [3:0] d;
        d = 4'(m_disp >> (4 * idx));
`ifdef BCD_SCAN_LZB_EN
        if (idx == 2 && m_disp[11:8] == 4'd0) return 7'b1111111;
        if (idx == 1 && m_disp[11:4] == 8'd0) return 7'b1111111;
`endif
        return pat_tab[d];
    endfunction

    task automatic model_edge(input logic ld, input logic [11:0] b);
        logic tk;
        int   idx;
        tk = ((m_cyc % N) == N - 1);
        if (m_prev_tick) begin
            idx   = m_nt % 3;
            m_an  = 3'b111 ^ (3'b001 << idx);
            m_seg = exp_pat(idx);
        end
        if (tk) begin
            m_an = 3'b111;
            if ((m_nt % 3) == 2 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            m_nt++;
        end
        if (ld) begin
            m_shadow = b;
            m_pend   = 1'b1;
        end
        m_prev_tick = tk;
        m_cyc++;
    endtask

    task automatic step(input logic ld, input logic [11:0] b);
        load = ld;
        bcd  = b;
        if (ld) $display("load bcd=%h at cycle %0d", b, m_cyc);
        @(posedge clk);
        model_edge(ld, b);
        #1;
        load = 1'b0;
        check_eq("an", 12'(an), 12'(m_an));
        check_eq("seg", 12'(seg), 12'(m_seg));
        check_eq("pending", 12'(pending), 12'(m_pend));
        if (watch_bad && (seg === pat_tab[4] || seg === pat_tab[5] || seg === pat_tab[6]))
            seen_bad = 1'b1;
    endtask

    task automatic wait_an(input logic [2:0] tgt, input logic [6:0] exp_seg, input string tag);
        int k;
        k = 0;
        while (an !== tgt && k < 60) begin
            step(1'b0, 12'h000);
            k++;
        end
        check_eq({tag, "_an"}, 12'(an), 12'(tgt));
        check_eq({tag, "_seg"}, 12'(seg), 12'(exp_seg));
    endtask

    task automatic wait_commit();
        int k;
        k = 0;
        while (m_pend && k < 200) begin
            step(1'b0, 12'h000);
            k++;
        end
        check_eq("commit_done", 12'(pending), 12'h000);
    endtask

    task automatic wait_frame_start();
        int k;
        k = 0;
        while (!(m_prev_tick && (m_nt % 3) == 0) && k < 100) begin
            step(1'b0, 12'h000);
            k++;
        end
        check_eq("frame_start", 12'(m_prev_tick), 12'h001);
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        load      = 1'b0;
        bcd       = 12'h000;
        watch_bad = 1'b0;
        seen_bad  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_an", 12'(an), 12'h007);
        check_eq("rst_seg", 12'(seg), 12'h07F);
        check_eq("rst_pending", 12'(pending), 12'h000);
        rst = 1'b0;

        // 123: pending until the hundreds tick, then shown U, T, H.
        step(1'b1, 12'h123);
        wait_commit();
        wait_an(3'b110, 7'b0110000, "u123");
        wait_an(3'b101, 7'b0100100, "t123");
        wait_an(3'b011, 7'b1111001, "h123");

        // Last write wins within a frame; 456 must never reach seg.
        wait_frame_start();
        watch_bad = 1'b1;
        step(1'b1, 12'h456);
        step(1'b0, 12'h000);
        step(1'b1, 12'h789);
        wait_commit();
        wait_an(3'b110, 7'b0010000, "u789");
        wait_an(3'b101, 7'b0000000, "t789");
        wait_an(3'b011, 7'b1111000, "h789");
        watch_bad = 1'b0;
        check_eq("no_456", 12'(seen_bad), 12'h000);

        // Load coinciding with the commit tick.
        wait_frame_start();
        step(1'b1, 12'h321);
        k = 0;
        while (!(((m_cyc % N) == N - 1) && (m_nt % 3) == 2) && k < 100) begin
            step(1'b0, 12'h000);
            k++;
        end
        step(1'b1, 12'h654);
        check_eq("coincide_pending", 12'(pending), 12'h001);
        wait_an(3'b110, 7'b1111001, "u321");
        wait_an(3'b011, 7'b0110000, "h321");
        wait_commit();
        wait_an(3'b110, 7'b0011001, "u654");

        // Invalid nibbles show a dash.
        step(1'b1, 12'h0AF);
        wait_commit();
`ifdef BCD_SCAN_LZB_EN
        wait_an(3'b011, 7'b1111111, "h0AF");
`else
        wait_an(3'b011, 7'b1000000, "h0AF");
`endif
        wait_an(3'b110, 7'b0111111, "u0AF");
        wait_an(3'b101, 7'b0111111, "t0AF");

`ifdef BCD_SCAN_LZB_EN
        step(1'b1, 12'h007);
        wait_commit();
        wait_an(3'b110, 7'b1111000, "u007");
        wait_an(3'b101, 7'b1111111, "t007");
        wait_an(3'b011, 7'b1111111, "h007");
        step(1'b1, 12'h000);
        wait_commit();
        wait_an(3'b110, 7'b1000000, "u000");
        wait_an(3'b101, 7'b1111111, "t000");
`endif

        // Random loads, including non-BCD nibbles.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(5, 0) == 0)
                step(1'b1, 12'($urandom));
            else
                step(1'b0, 12'h000);
        end

        // Asynchronous reset while the tens digit is lit, with a value still pending.
        step(1'b1, 12'h999);
        k = 0;
        while (!((m_nt % 3) == 1 && m_an != 3'b111 && m_pend) && k < 100) begin
            if (!m_pend)
                step(1'b1, 12'h999);
            else
                step(1'b0, 12'h000);
            k++;
        end
        check_eq("in_tens_slot", 12'(an), 12'h005);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_an", 12'(an), 12'h007);
        check_eq("arst_seg", 12'(seg), 12'h07F);
        check_eq("arst_pending", 12'(pending), 12'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_an(3'b101, 7'b1000000, "resume");
        for (int i = 0; i < 3 * N * 2; i++) step(1'b0, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
